divmod_hs: RTL and testbench

//   Iterative restoring divider, next generation of the divmod unit: width set by WIDTH_LOG,

---
 rtl/divmod_pkg.sv | 36 +++
 rtl/divmod_hs_if.sv | 36 +++
 rtl/prio_enc.sv | 26 ++
 rtl/divmod_hs.sv | 204 ++++++++++++++++++++
 tb/tb_divmod_hs.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divmod_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : divmod_pkg
//  Description : Shared definitions for the divmod divider family: FSM state
//                encoding, counter width helper and two's-complement helpers
//                (conditional negate, absolute value) on a 64-bit carrier.
//  Revision    : 1.0  initial release
// ============================================================================
package divmod_pkg;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Iteration counter must hold the value WIDTH itself, hence one extra bit
    // over an MSB index.
    function automatic int f_cnt_w(input int width_log);
        return width_log + 1;
    endfunction

    // Two's-complement negate when en is set. Callers truncate to their width;
    // the low bits of a 64-bit negate equal a native-width negate.
    function automatic logic [63:0] f_cneg(input logic [63:0] x, input logic en);
        return en ? (~x + 64'd1) : x;
    endfunction

    // Magnitude of a w-bit value (zero-extended into x). The magnitude of MIN
    // comes out as unsigned 2^(w-1), which still fits w bits.
    function automatic logic [63:0] f_abs(input logic [63:0] x, input int w,
                                          input logic is_signed);
        return f_cneg(x, is_signed & x[w-1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divmod_hs_if.sv
`default_nettype none
// ============================================================================
//  Interface   : divmod_hs_if
//  Description : Operand/result handshake bundle of the divmod_hs divider.
//                master = requester side, slave = divider side.
//  Revision    : 1.0  initial release
// ============================================================================
interface divmod_hs_if #(
    parameter int WIDTH_LOG = 4
);
    localparam int c_width = 1 << WIDTH_LOG;

    logic               in_valid;
    logic               in_ready;
    logic               is_signed;
    logic [c_width-1:0] a;
    logic [c_width-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [c_width-1:0] quot;
    logic [c_width-1:0] rem;
    logic               div0;
    logic               ovf;

    modport master (
        output in_valid, is_signed, a, b, out_ready,
        input  in_ready, out_valid, quot, rem, div0, ovf
    );

    modport slave (
        input  in_valid, is_signed, a, b, out_ready,
        output in_ready, out_valid, quot, rem, div0, ovf
    );

endinterface
`default_nettype wire

// File: rtl/prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc
//  Description : Priority encoder returning the index of the highest set bit.
//                Zero input yields index 0.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_enc #(
    parameter int WIDTH_LOG = 4
) (
    input  logic [(1<<WIDTH_LOG)-1:0] in_i,
    output logic [WIDTH_LOG-1:0]      idx_o
);

    // Scan upward so the last set bit seen (the MSB) wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < (1 << WIDTH_LOG); i++) begin
            if (in_i[i]) begin
                idx_o = WIDTH_LOG'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/divmod_hs.sv
`default_nettype none
// ============================================================================
//  Module      : divmod_hs
//  Description : Iterative restoring divider, one quotient bit per cycle,
//                runtime signed/unsigned, valid/ready on both sides, per-result
//                div0/ovf flags. One division in flight.
//                Optional macro DIVMOD_HS_EARLY_EXIT_EN: iterations limited to
//                msb(|a|)-msb(|b|)+1 with divisor alignment by priority encoders;
//                |a| < |b| finishes immediately. Results identical either way.
//  Revision    : 1.0  initial release
// ============================================================================
module divmod_hs
    import divmod_pkg::*;
#(
    parameter int WIDTH_LOG = 4
) (
    input  logic       clk,
    input  logic       rst,
    divmod_hs_if.slave bus
);

    localparam int                 c_width = 1 << WIDTH_LOG;
    localparam int                 c_cnt_w = f_cnt_w(WIDTH_LOG);
    localparam logic [c_width-1:0] c_min   = {1'b1, {(c_width-1){1'b0}}};

    // State
    logic [1:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q;
    logic [c_width-1:0] rem_q;        // partial remainder (always < divisor)
    logic [c_width-1:0] quo_q;        // dividend bits shifting out, quotient in
    logic [c_width-1:0] div_q;        // divisor magnitude
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [c_width-1:0] quot_q;
    logic [c_width-1:0] rem_out_q;
    logic               div0_q;
    logic               ovf_q;

    // Operand decode at accept
    logic               w_sa, w_sb;
    logic [c_width-1:0] w_amag, w_bmag;
    logic               w_div0, w_ovf, w_small, w_direct;
    logic [c_cnt_w-1:0] w_iters, w_shift;
    logic [2*c_width-1:0] w_init;

    // Iteration step
    logic [c_width:0]   w_rem_sh;     // WIDTH+1-bit shifted partial remainder
    logic               w_ge;
    logic [c_width-1:0] w_rem_nx, w_quo_nx;
    logic [c_width-1:0] w_quot_fix, w_rem_fix;
    logic               w_last;

    assign w_sa   = bus.is_signed & bus.a[c_width-1];
    assign w_sb   = bus.is_signed & bus.b[c_width-1];
    assign w_amag = c_width'(f_abs(64'(bus.a), c_width, bus.is_signed));
    assign w_bmag = c_width'(f_abs(64'(bus.b), c_width, bus.is_signed));
    assign w_div0 = (bus.b == '0);
    assign w_ovf  = bus.is_signed & (bus.a == c_min) & (bus.b == '1);

`ifdef DIVMOD_HS_EARLY_EXIT_EN
    logic [WIDTH_LOG-1:0] w_msb_a, w_msb_b;

    prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_pe_a (.in_i(w_amag), .idx_o(w_msb_a));
    prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_pe_b (.in_i(w_bmag), .idx_o(w_msb_b));

    // Only meaningful when |a| >= |b| > 0; other cases bypass CALC.
    assign w_small = (w_amag < w_bmag);
    assign w_iters = {1'b0, w_msb_a} - {1'b0, w_msb_b} + c_cnt_w'(1);
    assign w_shift = c_cnt_w'(c_width) - w_iters;
`else
    assign w_small = 1'b0;
    assign w_iters = c_cnt_w'(c_width);
    assign w_shift = '0;
`endif

    assign w_direct = w_div0 | w_ovf | w_small;

    // Pre-shifting the dividend skips leading iterations that would only
    // produce zero quotient bits; the upper half is the starting remainder.
    assign w_init = {{c_width{1'b0}}, w_amag} << w_shift;

    assign w_rem_sh = {rem_q, quo_q[c_width-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, div_q});
    // True difference is < divisor, so dropping the top bit is exact.
    assign w_rem_nx = w_ge ? (w_rem_sh[c_width-1:0] - div_q) : w_rem_sh[c_width-1:0];
    assign w_quo_nx = {quo_q[c_width-2:0], w_ge};
    assign w_last   = (cnt_q == c_cnt_w'(1));

    // Sign correction: truncation toward zero, remainder follows dividend.
    assign w_quot_fix = c_width'(f_cneg(64'(w_quo_nx), neg_quo_q));
    assign w_rem_fix  = c_width'(f_cneg(64'(w_rem_nx), neg_rem_q));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: special cases jump straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (bus.in_valid) begin
                    state_d = w_direct ? c_st_done : c_st_calc;
                end
            end
            c_st_calc: begin
                if (w_last) begin
                    state_d = c_st_done;
                end
            end
            c_st_done: begin
                if (bus.out_ready) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // FSM outputs: handshake flags decoded from state only.
    always_comb begin
        bus.in_ready  = (state_q == c_st_idle);
        bus.out_valid = (state_q == c_st_done);
    end

    // Datapath: load operands on accept, iterate in CALC, latch result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        rem_q     <= w_init[2*c_width-1:c_width];
                        quo_q     <= w_init[c_width-1:0];
                        div_q     <= w_bmag;
                        cnt_q     <= w_iters;
                        neg_quo_q <= w_sa ^ w_sb;
                        neg_rem_q <= w_sa;
                        if (w_div0) begin
                            quot_q    <= '1;
                            rem_out_q <= bus.a;
                            div0_q    <= 1'b1;
                            ovf_q     <= 1'b0;
                        end else if (w_ovf) begin
                            quot_q    <= c_min;
                            rem_out_q <= '0;
                            div0_q    <= 1'b0;
                            ovf_q     <= 1'b1;
                        end else if (w_small) begin
                            quot_q    <= '0;
                            rem_out_q <= bus.a;
                            div0_q    <= 1'b0;
                            ovf_q     <= 1'b0;
                        end
                    end
                end
                c_st_calc: begin
                    rem_q <= w_rem_nx;
                    quo_q <= w_quo_nx;
                    cnt_q <= cnt_q - c_cnt_w'(1);
                    if (w_last) begin
                        quot_q    <= w_quot_fix;
                        rem_out_q <= w_rem_fix;
                        div0_q    <= 1'b0;
                        ovf_q     <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.quot = quot_q;
    assign bus.rem  = rem_out_q;
    assign bus.div0 = div0_q;
    assign bus.ovf  = ovf_q;

`ifndef SYNTHESIS
    // Iteration counter must never reach zero while still calculating.
    always @(posedge clk) begin
        if (!rst && state_q == c_st_calc) begin
            assert (cnt_q != '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_divmod_hs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divmod_hs
//  Description : Scoreboard bench for divmod_hs (WIDTH_LOG=4). Driver pushes
//                expected results on accept; a monitor pops and compares when
//                the divider presents a result. Works with and without
//                DIVMOD_HS_EARLY_EXIT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_divmod_hs;

    localparam int WL = 4;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        d0;
        logic        ov;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    divmod_hs_if #(.WIDTH_LOG(WL)) dm_if ();

    divmod_hs #(.WIDTH_LOG(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dm_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected cycles from accept to out_valid.
    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b, input logic sg);
        logic [15:0] am, bm;
        int ma, mb;
        if (b == 16'h0) return 1;
        if (sg && a == 16'h8000 && b == 16'hFFFF) return 1;
        am = (sg && a[15]) ? (~a + 16'd1) : a;
        bm = (sg && b[15]) ? (~b + 16'd1) : b;
        ma = 0;
        mb = 0;
        for (int i = 0; i < 16; i++) begin
            if (am[i]) ma = i;
            if (bm[i]) mb = i;
        end
`ifdef DIVMOD_HS_EARLY_EXIT_EN
        if (am < bm) return 1;
        return ma - mb + 2;
`else
        return 17;
`endif
    endfunction

    // Drive one operation (caller sits at a negedge); push expectation on accept.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sg,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic ed0, input logic eov, input int id);
        exp_t e;
        int   n;
        dm_if.in_valid  = 1'b1;
        dm_if.a         = a;
        dm_if.b         = b;
        dm_if.is_signed = sg;
        n = 0;
        while (dm_if.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (dm_if.in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout id=%0d in_ready=%b want 1", id, dm_if.in_ready);
        end else begin
            e.q   = eq;
            e.r   = er;
            e.d0  = ed0;
            e.ov  = eov;
            e.lat = exp_lat(a, b, sg);
            e.acc = cyc;
            e.id  = id;
            sb.push_back(e);
        end
        @(negedge clk);
        dm_if.in_valid = 1'b0;
    endtask

    // Reference model for the random section.
    task automatic ref_send(input logic [15:0] a, input logic [15:0] b, input logic sg,
                            input int id);
        logic [15:0] q, r;
        logic        d0, ov;
        d0 = 1'b0;
        ov = 1'b0;
        if (b == 16'h0) begin
            q  = 16'hFFFF;
            r  = a;
            d0 = 1'b1;
        end else if (sg && a == 16'h8000 && b == 16'hFFFF) begin
            q  = 16'h8000;
            r  = 16'h0;
            ov = 1'b1;
        end else if (sg) begin
            q = 16'($signed(a) / $signed(b));
            r = 16'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        send(a, b, sg, q, r, d0, ov, id);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || dm_if.in_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || dm_if.in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d in_ready=%b want 0/1", sb.size(), dm_if.in_ready);
        end
    endtask

    // Monitor: checks every cycle a result is presented, latency on its rise,
    // and the IDLE cycle following each taken result.
    exp_t mon_e;
    logic prev_ov  = 1'b0;
    logic chk_idle = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (rst !== 1'b0) begin
            prev_ov  = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                total++;
                if (dm_if.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL idle_after_take in_ready=%b want 1", dm_if.in_ready);
                end
                chk_idle = 1'b0;
            end
            if (dm_if.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result quot=%h rem=%h want none", dm_if.quot, dm_if.rem);
                end else begin
                    mon_e = sb[0];
                    total++;
                    if (dm_if.quot !== mon_e.q || dm_if.rem !== mon_e.r ||
                        dm_if.div0 !== mon_e.d0 || dm_if.ovf !== mon_e.ov ||
                        dm_if.in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL result id=%0d got q=%h r=%h d0=%b ov=%b rdy=%b want q=%h r=%h d0=%b ov=%b rdy=0",
                                 mon_e.id, dm_if.quot, dm_if.rem, dm_if.div0, dm_if.ovf,
                                 dm_if.in_ready, mon_e.q, mon_e.r, mon_e.d0, mon_e.ov);
                    end
                    if (!prev_ov) begin
                        total++;
                        if (cyc - mon_e.acc != mon_e.lat) begin
                            bad++;
                            $display("FAIL latency id=%0d got %0d want %0d",
                                     mon_e.id, cyc - mon_e.acc, mon_e.lat);
                        end
                    end
                    if (dm_if.out_ready === 1'b1) begin
                        void'(sb.pop_front());
                        chk_idle = 1'b1;
                    end
                end
            end
            prev_ov = dm_if.out_valid;
        end
    end

    initial begin
        int          n;
        logic [15:0] ra, rb;
        logic        rs;
        rst             = 1'b1;
        dm_if.in_valid  = 1'b0;
        dm_if.is_signed = 1'b0;
        dm_if.a         = '0;
        dm_if.b         = '0;
        dm_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        total++;
        if (dm_if.out_valid !== 1'b0 || dm_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_hs out_valid=%b in_ready=%b want 0 1", dm_if.out_valid, dm_if.in_ready);
        end
        total++;
        if (dm_if.quot !== 16'h0 || dm_if.rem !== 16'h0 || dm_if.div0 !== 1'b0 || dm_if.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_data q=%h r=%h d0=%b ov=%b want 0 0 0 0",
                     dm_if.quot, dm_if.rem, dm_if.div0, dm_if.ovf);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        send(16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 1);
        send(16'hFFF9, 16'd2,    1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 2);
        send(16'd7,    16'hFFFE, 1'b1, 16'hFFFD, 16'd1,    1'b0, 1'b0, 3);
        send(16'hFFF9, 16'hFFFE, 1'b1, 16'd3,    16'hFFFF, 1'b0, 1'b0, 4);
        send(16'h1234, 16'h0,    1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 5);
        send(16'h1234, 16'h0,    1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 6);
        send(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0,    1'b0, 1'b1, 7);
        send(16'h8000, 16'hFFFF, 1'b0, 16'h0,    16'h8000, 1'b0, 1'b0, 8);
        send(16'h8000, 16'd2,    1'b1, 16'hC000, 16'h0,    1'b0, 1'b0, 9);
        send(16'd5,    16'd9,    1'b0, 16'd0,    16'd5,    1'b0, 1'b0, 10);
        send(16'hFFFF, 16'd1,    1'b0, 16'hFFFF, 16'h0,    1'b0, 1'b0, 11);
        send(16'hFFFB, 16'd9,    1'b1, 16'h0,    16'hFFFB, 1'b0, 1'b0, 12);
        wait_idle();

        // Stall in DONE for 10 cycles with a competing request held on the input
        dm_if.out_ready = 1'b0;
        send(16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0, 1'b0, 13);
        n = 0;
        while (dm_if.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        dm_if.in_valid  = 1'b1;
        dm_if.a         = 16'd50;
        dm_if.b         = 16'd7;
        dm_if.is_signed = 1'b0;
        repeat (10) @(negedge clk);
        dm_if.out_ready = 1'b1;
        send(16'd50, 16'd7, 1'b0, 16'd7, 16'd1, 1'b0, 1'b0, 14);
        send(16'hFF9C, 16'd10, 1'b1, 16'hFFF6, 16'h0, 1'b0, 1'b0, 15);
        wait_idle();

        // Asynchronous reset in the middle of a calculation
        dm_if.in_valid  = 1'b1;
        dm_if.a         = 16'hFFFF;
        dm_if.b         = 16'd1;
        dm_if.is_signed = 1'b0;
        @(negedge clk);
        dm_if.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (dm_if.out_valid !== 1'b0 || dm_if.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL calc_busy out_valid=%b in_ready=%b want 0 0", dm_if.out_valid, dm_if.in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (dm_if.out_valid !== 1'b0 || dm_if.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset out_valid=%b in_ready=%b want 0 1", dm_if.out_valid, dm_if.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send(16'd200, 16'd13, 1'b0, 16'd15, 16'd5, 1'b0, 1'b0, 16);

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rb = 16'h0;
                1:       begin ra = 16'h8000; rb = 16'hFFFF; end
                2, 3:    rb = 16'($urandom_range(1, 20));
                4:       rb = 16'hFFFF - 16'($urandom_range(0, 5));
                default: rb = 16'($urandom);
            endcase
            ref_send(ra, rb, rs, 100 + i);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
